// File: rtl/bus_if_wbuf_pkg.sv
// rtl/bus_if_wbuf_pkg.sv - shared encodings for the CPU-side bus interface
package bus_if_wbuf_pkg;

  typedef enum logic [1:0] {
    BUS_IF_STATE_IDLE   = 2'd0,
    BUS_IF_STATE_REQ    = 2'd1,
    BUS_IF_STATE_ACCESS = 2'd2,
    BUS_IF_STATE_STALL  = 2'd3
  } bus_if_state_e;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/bus_if_wfifo.sv
// rtl/bus_if_wfifo.sv - posted-write buffer, DEPTH x W synchronous FIFO
module bus_if_wfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus_if_wbuf.sv
// rtl/bus_if_wbuf.sv - CPU memory interface: SPM window, posted bus writes, read ordering, timeout
module bus_if_wbuf
  import bus_if_wbuf_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int SIDX_HI    = 29,
  parameter int SIDX_LO    = 27,
  parameter int SPM_INDEX  = 1,
  parameter int WBUF_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  output logic          busy,
  output logic          err,
  input  logic [AW-1:0] addr,
  input  logic          as_,
  input  logic          rw,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  input  logic [DW-1:0] spm_rd_data,
  output logic [AW-1:0] spm_addr,
  output logic          spm_as_,
  output logic          spm_rw,
  output logic [DW-1:0] spm_wr_data,
  input  logic [DW-1:0] bus_rd_data,
  input  logic          bus_rdy_,
  input  logic          bus_grnt_,
  output logic          bus_req_,
  output logic [AW-1:0] bus_addr,
  output logic          bus_as_,
  output logic          bus_rw,
  output logic [DW-1:0] bus_wr_data
);

  localparam int SIDX_W = SIDX_HI - SIDX_LO + 1;
  localparam int TW     = clog2_min1(TIMEOUT + 1);
  localparam int CW     = $clog2(WBUF_DEPTH) + 1;

  bus_if_state_e state, state_nx;
  logic          bus_req_nx, bus_as_nx, bus_rw_nx;
  logic [AW-1:0] bus_addr_nx, head_addr;
  logic [DW-1:0] bus_wr_data_nx, head_data, rd_buf, rd_buf_nx, rd_now;
  logic [TW-1:0] tmo_cnt, tmo_cnt_nx;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty, push, pop;
  logic          valid, is_spm, spm_acc, bus_wr, bus_rd;
  logic          timed_out, acc_end, rd_done;

  assign spm_addr    = addr;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;

  assign valid   = !as_ && !flush;
  assign is_spm  = (addr[SIDX_HI:SIDX_LO] == SIDX_W'(SPM_INDEX));
  assign spm_acc = valid && is_spm;
  assign bus_wr  = valid && !is_spm && (rw == WRITE);
  assign bus_rd  = valid && !is_spm && (rw == READ);
  assign push    = bus_wr && !fifo_full && !stall;

  assign timed_out = (TIMEOUT != 0) && (tmo_cnt == TW'(TIMEOUT));
  assign acc_end   = (state == BUS_IF_STATE_ACCESS) && (!bus_rdy_ || timed_out);
  assign rd_done   = acc_end && (bus_rw == READ);
  assign rd_now    = bus_rdy_ ? '0 : bus_rd_data;

  bus_if_wfifo #(.DEPTH(WBUF_DEPTH), .W(AW + DW)) u_wfifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({addr, wr_data}),
    .dout  ({head_addr, head_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BUS_IF_STATE_IDLE;
      bus_req_    <= DISABLE_;
      bus_as_     <= DISABLE_;
      bus_addr    <= '0;
      bus_rw      <= READ;
      bus_wr_data <= '0;
      tmo_cnt     <= '0;
      rd_buf      <= '0;
    end else begin
      state       <= state_nx;
      bus_req_    <= bus_req_nx;
      bus_as_     <= bus_as_nx;
      bus_addr    <= bus_addr_nx;
      bus_rw      <= bus_rw_nx;
      bus_wr_data <= bus_wr_data_nx;
      tmo_cnt     <= tmo_cnt_nx;
      rd_buf      <= rd_buf_nx;
    end
  end

  // Buffered writes always go first so a later read never overtakes them.
  always_comb begin
    state_nx       = state;
    bus_req_nx     = bus_req_;
    bus_as_nx      = DISABLE_;
    bus_addr_nx    = bus_addr;
    bus_rw_nx      = bus_rw;
    bus_wr_data_nx = bus_wr_data;
    tmo_cnt_nx     = tmo_cnt;
    rd_buf_nx      = rd_buf;
    pop            = 1'b0;
    case (state)
      BUS_IF_STATE_IDLE: begin
        if (!fifo_empty) begin
          state_nx       = BUS_IF_STATE_REQ;
          bus_req_nx     = ENABLE_;
          bus_addr_nx    = head_addr;
          bus_rw_nx      = WRITE;
          bus_wr_data_nx = head_data;
        end else if (bus_rd) begin
          state_nx       = BUS_IF_STATE_REQ;
          bus_req_nx     = ENABLE_;
          bus_addr_nx    = addr;
          bus_rw_nx      = READ;
          bus_wr_data_nx = '0;
        end
      end
      BUS_IF_STATE_REQ: begin
        if (!bus_grnt_) begin
          state_nx  = BUS_IF_STATE_ACCESS;
          bus_as_nx = ENABLE_;
        end
      end
      BUS_IF_STATE_ACCESS: begin
        if (acc_end) begin
          bus_req_nx     = DISABLE_;
          bus_addr_nx    = '0;
          bus_rw_nx      = READ;
          bus_wr_data_nx = '0;
          tmo_cnt_nx     = '0;
          pop            = (bus_rw == WRITE);
          if (bus_rw == READ) rd_buf_nx = rd_now;
          state_nx = (stall && (bus_rw == READ)) ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
        end else begin
          tmo_cnt_nx = tmo_cnt + 1'b1;
        end
      end
      BUS_IF_STATE_STALL: begin
        if (!stall) state_nx = BUS_IF_STATE_IDLE;
      end
      default: state_nx = BUS_IF_STATE_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    spm_as_ = DISABLE_;
    busy    = 1'b0;
    err     = acc_end && bus_rdy_;
    if (rd_done)
      rd_data = rd_now;
    else if ((state == BUS_IF_STATE_STALL) && (rw == READ))
      rd_data = rd_buf;
    if (spm_acc) begin
      if (!stall) begin
        spm_as_ = ENABLE_;
        if (rw == READ) rd_data = spm_rd_data;
      end
    end else if (bus_wr) begin
      busy = (fifo_count == CW'(WBUF_DEPTH));
    end else if (bus_rd) begin
      busy = !(rd_done || (state == BUS_IF_STATE_STALL));
    end
  end

endmodule

// File: tb/tb_bus_if_wbuf.sv
// tb/tb_bus_if_wbuf.sv - directed self-checking bench for bus_if_wbuf
module tb_bus_if_wbuf;

  logic        clk = 1'b0;
  logic        reset, stall, flush, as_, rw;
  logic        busy, err, spm_as_, spm_rw, bus_rdy_, bus_grnt_, bus_req_, bus_as_, bus_rw;
  logic [31:0] addr, wr_data, rd_data, spm_rd_data, spm_addr, spm_wr_data;
  logic [31:0] bus_rd_data, bus_addr, bus_wr_data;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  bus_if_wbuf #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy), .err(err),
    .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data), .rd_data(rd_data),
    .spm_rd_data(spm_rd_data), .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
    .bus_grnt_(bus_grnt_), .bus_req_(bus_req_), .bus_addr(bus_addr), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_wr_data(bus_wr_data)
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    as_ = 1'b1; rw = 1'b1; stall = 1'b0; flush = 1'b0;
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus_idle();
    addr = '0; wr_data = '0; spm_rd_data = '0; bus_rd_data = '0;
    @(negedge clk);
    checks++;
    if ({bus_req_, bus_as_, bus_rw, err, spm_as_, busy} !== 6'b111010) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 111010", {bus_req_, bus_as_, bus_rw, err, spm_as_, busy});
    end
    checks++;
    if ({bus_addr, bus_wr_data, rd_data} !== 96'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {bus_addr, bus_wr_data, rd_data});
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_spm_read;
    addr = 32'h0800_0010; rw = 1'b1; as_ = 1'b0; spm_rd_data = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if ({spm_as_, busy, rd_data} !== {1'b0, 1'b0, 32'h1234_5678}) begin
      errors++; $display("FAIL spm_read: got as_=%b busy=%b rd=%h expected 0 0 12345678", spm_as_, busy, rd_data);
    end
    checks++;
    if ({spm_addr, spm_rw} !== {32'h0800_0010, 1'b1}) begin
      errors++; $display("FAIL spm_passthru: got %h/%b expected 08000010/1", spm_addr, spm_rw);
    end
    stall = 1'b1;
    #1;
    checks++;
    if ({spm_as_, busy, rd_data} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL spm_stall: got as_=%b busy=%b rd=%h expected 1 0 0", spm_as_, busy, rd_data);
    end
    next_cycle();
    bus_idle();
    @(negedge clk);
    checks++;
    if (bus_req_ !== 1'b1) begin
      errors++; $display("FAIL spm_no_bus: got bus_req_=%b expected 1", bus_req_);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back;
    int  seen = 0;
    int  dbl = 0;
    bit  prev_low = 1'b0;
    rw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      addr = 32'h1000_0000 + 32'(i * 4);
      wr_data = 32'hA000_0000 + 32'(i);
      as_ = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== (i == 4)) begin
        errors++; $display("FAIL wbuf_busy[%0d]: got %b expected %b", i, busy, (i == 4));
      end
      next_cycle();
    end
    as_ = 1'b1;
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus_as_ === 1'b0) begin
        if (prev_low) dbl++;
        if (seen < 4) begin
          checks++;
          if ({bus_rw, bus_addr, bus_wr_data} !== {1'b0, 32'h1000_0000 + 32'(seen * 4), 32'hA000_0000 + 32'(seen)}) begin
            errors++; $display("FAIL drain[%0d]: got %b %h %h expected 0 %h %h", seen, bus_rw, bus_addr, bus_wr_data,
                               32'h1000_0000 + 32'(seen * 4), 32'hA000_0000 + 32'(seen));
          end
        end
        seen++;
        prev_low = 1'b1;
      end else begin
        prev_low = 1'b0;
      end
    end
    checks++;
    if (seen !== 4) begin
      errors++; $display("FAIL drain_count: got %0d expected 4", seen);
    end
    checks++;
    if (dbl !== 0) begin
      errors++; $display("FAIL bus_as_width: got %0d double-cycle strobes expected 0", dbl);
    end
    next_cycle();
    bus_idle();
  endtask

  task automatic test_write_then_read;
    bit wr_seen = 1'b0;
    bit done = 1'b0;
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFE_F00D;
    addr = 32'h1000_0000; rw = 1'b0; wr_data = 32'h5555_AAAA; as_ = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL wr_post_busy: got %b expected 0", busy);
    end
    next_cycle();
    rw = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus_as_ === 1'b0 && bus_rw === 1'b1) begin
        done = 1'b1;
        checks++;
        if (wr_seen !== 1'b1) begin
          errors++; $display("FAIL order: got write_before_read=%b expected 1", wr_seen);
        end
        checks++;
        if ({bus_addr, rd_data, busy} !== {32'h1000_0000, 32'hCAFE_F00D, 1'b0}) begin
          errors++; $display("FAIL rd_result: got %h %h %b expected 10000000 cafef00d 0", bus_addr, rd_data, busy);
        end
      end else begin
        if (bus_as_ === 1'b0) begin
          wr_seen = 1'b1;
          checks++;
          if ({bus_addr, bus_wr_data} !== {32'h1000_0000, 32'h5555_AAAA}) begin
            errors++; $display("FAIL wr_before_rd: got %h %h expected 10000000 5555aaaa", bus_addr, bus_wr_data);
          end
        end
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL rd_wait_busy: got %b expected 1", busy);
        end
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL rd_timeout: got done=%b expected 1", done);
    end
    next_cycle();
    bus_idle();
  endtask

  task automatic test_timeout;
    int k = -1;
    int err_cnt = 0;
    int err_k = -1;
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b1; bus_rd_data = 32'hFFFF_FFFF;
    addr = 32'h1000_0040; rw = 1'b1; as_ = 1'b0;
    for (int c = 0; c < 40 && k < 12; c++) begin
      @(negedge clk);
      if (bus_as_ === 1'b0) k = 0;
      else if (k >= 0) k++;
      if (k == 4) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL tmo_wait_busy: got %b expected 1", busy);
        end
      end
      if (k == 9) begin
        checks++;
        if ({bus_req_, busy, err} !== 3'b100) begin
          errors++; $display("FAIL tmo_after: got req_/busy/err=%b expected 100", {bus_req_, busy, err});
        end
      end
      if (err === 1'b1) begin
        err_cnt++;
        err_k = k;
        checks++;
        if ({rd_data, busy} !== {32'h0, 1'b0}) begin
          errors++; $display("FAIL tmo_result: got rd=%h busy=%b expected 0 0", rd_data, busy);
        end
        next_cycle();
        as_ = 1'b1;
      end
    end
    checks++;
    if (err_cnt !== 1 || err_k !== 8) begin
      errors++; $display("FAIL tmo_err_pulse: got %0d pulses at %0d expected 1 at 8", err_cnt, err_k);
    end
    next_cycle();
    bus_idle();
  endtask

  task automatic test_stall_read;
    bit done = 1'b0;
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'h1357_9BDF;
    stall = 1'b1; addr = 32'h1000_0080; rw = 1'b1; as_ = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus_as_ === 1'b0) begin
        done = 1'b1;
        checks++;
        if ({rd_data, busy} !== {32'h1357_9BDF, 1'b0}) begin
          errors++; $display("FAIL stall_rd_done: got %h %b expected 13579bdf 0", rd_data, busy);
        end
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL stall_rd_timeout: got done=%b expected 1", done);
    end
    next_cycle();
    bus_rd_data = 32'hDEAD_BEEF;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      checks++;
      if ({rd_data, busy, bus_req_} !== {32'h1357_9BDF, 1'b0, 1'b1}) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h %b %b expected 13579bdf 0 1", s, rd_data, busy, bus_req_);
      end
      next_cycle();
    end
    stall = 1'b0; as_ = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_data !== 32'h1357_9BDF) begin
      errors++; $display("FAIL stall_release: got %h expected 13579bdf", rd_data);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({rd_data, bus_req_} !== {32'h0, 1'b1}) begin
      errors++; $display("FAIL stall_to_idle: got %h %b expected 0 1", rd_data, bus_req_);
    end
    next_cycle();
    bus_idle();
  endtask

  task automatic test_flush;
    flush = 1'b1; addr = 32'h1000_0000; rw = 1'b1; as_ = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_busy: got %b expected 0", busy);
    end
    addr = 32'h0800_0000;
    #1;
    checks++;
    if (spm_as_ !== 1'b1) begin
      errors++; $display("FAIL flush_spm: got %b expected 1", spm_as_);
    end
    addr = 32'h1000_0000;
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus_req_ !== 1'b1) begin
      errors++; $display("FAIL flush_no_req: got %b expected 1", bus_req_);
    end
    next_cycle();
    bus_idle();
  endtask

  task automatic test_reset_mid_access;
    bit found = 1'b0;
    rw = 1'b0;
    for (int i = 0; i < 2; i++) begin
      addr = 32'h1000_0100 + 32'(i * 4); wr_data = 32'hB000_0000 + 32'(i); as_ = 1'b0;
      next_cycle();
    end
    as_ = 1'b1; bus_grnt_ = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus_as_ === 1'b0) found = 1'b1;
    end
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL rst_reach_access: got %b expected 1", found);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus_req_, bus_as_, bus_rw, err, busy, bus_addr, bus_wr_data} !== {5'b11100, 64'h0}) begin
      errors++; $display("FAIL rst_mid_access: got %b %h %h expected 11100 0 0",
                         {bus_req_, bus_as_, bus_rw, err, busy}, bus_addr, bus_wr_data);
    end
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bus_req_, bus_as_} !== 2'b11) begin
        errors++; $display("FAIL rst_buf_empty[%0d]: got %b expected 11", c, {bus_req_, bus_as_});
      end
    end
    next_cycle();
    bus_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_spm_read();
    test_back_to_back();
    test_write_then_read();
    test_timeout();
    test_stall_read();
    test_flush();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
